// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller for a pipeline MEM stage.
// Each access holds the SRAM for WAIT_CYCLES clocks while stalling the pipeline via ready.
module sram_ctrl #(
  parameter int          WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        SRAM_WE_N,
  output logic [15:0] SRAM_ADDR,
  inout  wire  [31:0] SRAM_DQ
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   sram_addr_q, sram_addr_d;
  logic [31:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      wdata_q     <= '0;
      sram_addr_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      wdata_q     <= wdata_d;
      sram_addr_q <= sram_addr_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    wdata_d     = wdata_q;
    sram_addr_d = sram_addr_q;
    rdata_d     = rdata_q;
    ready       = 1'b0;
    case (state_q)
      IDLE: begin
        ready = !(rd_en || wr_en);
        if (rd_en || wr_en) begin
          state_d     = ACCESS;
          cnt_d       = '0;
          // A simultaneous read and write request resolves to a write.
          is_wr_d     = wr_en;
          wdata_d     = wdata;
          sram_addr_d = 16'((address - BASE_ADDR) >> 2);
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (!is_wr_q) begin
            rdata_d = SRAM_DQ;
          end
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The write strobe is a single-cycle pulse at the start of the access; data is held for the whole access.
  assign SRAM_WE_N = !((state_q == ACCESS) && is_wr_q && (cnt_q == '0));
  assign SRAM_DQ   = ((state_q == ACCESS) && is_wr_q) ? wdata_q : 32'bz;
  assign SRAM_ADDR = sram_addr_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural SRAM model plus write/read scoreboards.
module tb_sram_ctrl;
  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        SRAM_WE_N;
  logic [15:0] SRAM_ADDR;
  wire  [31:0] sram_dq;

  int          tests_run = 0;
  int          fails = 0;
  int          we_low_cnt = 0;
  logic [47:0] wq[$];
  logic [31:0] rq[$];
  logic [31:0] ref_mem[int];
  logic [31:0] last_rd = '0;
  logic        tb_drive = 1'b0;
  logic [31:0] sram_mem[0:65535];

  always #5 clk = ~clk;

  sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(sram_dq)
  );

  // SRAM model: drives the bus only while the bench expects a read.
  assign sram_dq = tb_drive ? sram_mem[SRAM_ADDR] : 32'bz;
  always @(posedge clk) if (!SRAM_WE_N) sram_mem[SRAM_ADDR] <= sram_dq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("[TB] ok %s = %h", tag, obs);
    end
  endtask

  // Every write strobe must match the oldest outstanding write.
  always @(negedge clk) begin
    if (rst && !SRAM_WE_N) begin
      we_low_cnt++;
      if (wq.size() == 0) begin
        check("we_stray", {31'd0, SRAM_WE_N}, 32'd1);
      end else begin
        logic [47:0] e;
        e = wq.pop_front();
        check("we_addr", {16'd0, SRAM_ADDR}, {16'd0, e[47:32]});
        check("we_data", sram_dq, e[31:0]);
      end
    end
  end

  task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [15:0] exp_sa, input bit hold);
    int lowc;
    logic [31:0] e;
    if (wr) begin
      wq.push_back({exp_sa, data});
      ref_mem[int'(exp_sa)] = data;
    end else begin
      rq.push_back(ref_mem[int'(exp_sa)]);
    end
    tb_drive   = !wr;
    we_low_cnt = 0;
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = addr; wdata = data;
    lowc = 0;
    #1;
    while (!ready && lowc < 40) begin
      lowc++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", lowc, W + 1);
    if (!wr) begin
      e = rq.pop_front();
      check("rdata", rdata, e);
      last_rd = e;
    end else begin
      check("rdata_hold", rdata, last_rd);
    end
    check("we_pulses", we_low_cnt, wr ? 32'd1 : 32'd0);
    tb_drive = 1'b0;
    if (!hold) begin
      wr_en = 1'b0; rd_en = 1'b0;
    end
  endtask

  task automatic reset_mid_read();
    int lowc;
    tb_drive = 1'b1;
    @(negedge clk);
    rd_en = 1'b1; address = 32'd1032;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("abort_addr", {16'd0, SRAM_ADDR}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    rd_en = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1; tb_drive = 1'b0; last_rd = '0;
    lowc = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (!ready) lowc++;
    end
    check("abort_idle_low", lowc, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d[4];
    #3;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("rst_addr", {16'd0, SRAM_ADDR}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_access(1'b1, 1'b0, 32'd1024, 32'h0000_0011, 16'd0, 1'b0);
    do_access(1'b0, 1'b1, 32'd1024, 32'd0, 16'd0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1028, 32'hFFFF_FFFB, 16'd1, 1'b0);
    do_access(1'b1, 1'b0, 32'd1032, 32'd9, 16'd2, 1'b0);
    do_access(1'b0, 1'b1, 32'd1028, 32'd0, 16'd1, 1'b0);
    do_access(1'b0, 1'b1, 32'd1032, 32'd0, 16'd2, 1'b1);
    do_access(1'b0, 1'b1, 32'd1032, 32'd0, 16'd2, 1'b0);
    do_access(1'b1, 1'b1, 32'd1036, 32'd7, 16'd3, 1'b0);
    do_access(1'b0, 1'b1, 32'd1036, 32'd0, 16'd3, 1'b0);
    do_access(1'b1, 1'b0, 32'd0, 32'h0000_0055, 16'hFF00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom;
      do_access(1'b1, 1'b0, 32'd1056 + 32'(4 * k), d[k], 16'(8 + k), 1'b0);
    end
    for (int k = 3; k >= 0; k--) begin
      do_access(1'b0, 1'b1, 32'd1056 + 32'(4 * k), 32'd0, 16'(8 + k), 1'b0);
    end
    do_access(1'b0, 1'b1, 32'd0, 32'd0, 16'hFF00, 1'b0);

    reset_mid_read();
    do_access(1'b0, 1'b1, 32'd1024, 32'd0, 16'd0, 1'b0);

    @(negedge clk);
    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
